// File: rtl/timer_bank_pkg.sv
// timer_bank_pkg
//   Shared constants for the timer bank: register word offsets within a
//   channel, CTRL bit positions, MODE encodings and the channel stride.
//   No ports; imported by timer_channel and timer_bank.
package timer_bank_pkg;

  // Word offsets inside one channel's register window
  localparam int OFF_CTRL   = 0;
  localparam int OFF_PRESET = 1;
  localparam int OFF_COUNT  = 2;

  // Each channel occupies this many consecutive words
  localparam int CH_STRIDE  = 4;

  // CTRL bit positions
  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM       = 3;
  localparam int CTRL_PEND     = 4;
  localparam int CTRL_W        = 5;

  // MODE encodings; 2'b1x is reserved and behaves as one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

endpackage

// File: rtl/timer_bank_if.sv
// timer_bank_if
//   Peripheral-bus signals between the CPU bridge and the timer bank.
//   sel   : device select from the bridge
//   addr  : word offset within the device (byte address bits [6:2])
//   we    : write strobe, qualified by sel
//   be    : byte enables; only full-word writes take effect
//   wd    : write data
//   rd    : read data, combinational from addr
//   Modports: master (bridge side), slave (device side).
interface timer_bank_if;
  logic        sel;
  logic [4:0]  addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (output sel, addr, we, be, wd, input rd);
  modport slave  (input sel, addr, we, be, wd, output rd);
endinterface

// File: rtl/timer_bank_channel.sv
// timer_channel
//   One down-counting timer: CTRL (EN, MODE, IM, PEND), PRESET and COUNT
//   registers plus expiry and interrupt logic.
//   clk, reset     : clock, async active-low reset
//   ctrl_we        : full-word write to this channel's CTRL
//   preset_we      : full-word write to this channel's PRESET (also loads COUNT)
//   wd             : bus write data
//   ctrl           : {PEND, IM, MODE, EN} for readback
//   preset, count  : register values for readback
//   irq            : PEND & IM
module timer_channel
  import timer_bank_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ctrl_we,
  input  logic              preset_we,
  input  logic [31:0]       wd,
  output logic [CTRL_W-1:0] ctrl,
  output logic [CNT_W-1:0]  preset,
  output logic [CNT_W-1:0]  count,
  output logic              irq
);

  logic       en;
  logic [1:0] mode;
  logic       im;
  logic       pend;

  logic             expire;
  logic             reload;
  logic [CNT_W-1:0] wdCnt;
  logic             unusedWd;

  assign wdCnt    = wd[CNT_W-1:0];
  assign unusedWd = ^wd;

  // Expiry happens in the cycle COUNT sits at 1 with the timer running;
  // the PEND/reload/stop effects land on the following edge.
  assign expire = en && (count == CNT_W'(1));
  assign reload = (mode == MODE_RELOAD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en     <= 1'b0;
      mode   <= MODE_ONESHOT;
      im     <= 1'b0;
      pend   <= 1'b0;
      preset <= '0;
      count  <= '0;
    end else begin
      // A PRESET write overrides whatever the count would have done.
      if (preset_we) begin
        preset <= wdCnt;
        count  <= wdCnt;
      end else if (expire) begin
        count <= reload ? preset : '0;
      end else if (en && (count != '0)) begin
        count <= count - CNT_W'(1);
      end

      // A written EN beats the one-shot auto-clear.
      if (ctrl_we) begin
        en   <= wd[CTRL_EN];
        mode <= wd[CTRL_MODE_MSB:CTRL_MODE_LSB];
        im   <= wd[CTRL_IM];
      end else if (expire && !reload) begin
        en <= 1'b0;
      end

      // Expiry wins over a simultaneous write-1-to-clear.
      if (expire) begin
        pend <= 1'b1;
      end else if (ctrl_we && wd[CTRL_PEND]) begin
        pend <= 1'b0;
      end
    end
  end

  always_comb begin
    ctrl                              = '0;
    ctrl[CTRL_EN]                     = en;
    ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB] = mode;
    ctrl[CTRL_IM]                     = im;
    ctrl[CTRL_PEND]                   = pend;
  end

  assign irq = pend & im;

endmodule

// File: rtl/timer_bank.sv
// timer_bank
//   Bank of NCH down-counting timers on the peripheral bus. Holds the
//   address decode, read mux and irq concatenation; the per-channel
//   registers live in timer_channel.
//   clk    : system clock, rising edge
//   reset  : asynchronous active-low reset
//   bus    : peripheral bus slave (sel, addr, we, be, wd, rd)
//   irq    : per-channel interrupt requests, drives HWInt
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int NCH   = 6,
  parameter int CNT_W = 32
) (
  input  logic           clk,
  input  logic           reset,
  timer_bank_if.slave    bus,
  output logic [NCH-1:0] irq
);

  logic                 writeOk;
  logic [NCH-1:0]       ctrlWe;
  logic [NCH-1:0]       presetWe;
  logic [CTRL_W-1:0]    ctrlArr   [NCH];
  logic [CNT_W-1:0]     presetArr [NCH];
  logic [CNT_W-1:0]     countArr  [NCH];
  logic [31:0]          rdVal;

  assign writeOk = bus.sel && bus.we && (bus.be == 4'b1111);

  for (genvar g = 0; g < NCH; g++) begin : gCh
    assign ctrlWe[g]   = writeOk && (bus.addr == 5'(g * CH_STRIDE + OFF_CTRL));
    assign presetWe[g] = writeOk && (bus.addr == 5'(g * CH_STRIDE + OFF_PRESET));

    timer_channel #(.CNT_W(CNT_W)) uCh (
      .clk       (clk),
      .reset     (reset),
      .ctrl_we   (ctrlWe[g]),
      .preset_we (presetWe[g]),
      .wd        (bus.wd),
      .ctrl      (ctrlArr[g]),
      .preset    (presetArr[g]),
      .count     (countArr[g]),
      .irq       (irq[g])
    );
  end

  // Offsets that match no channel register (reserved words and anything
  // past the last channel) fall through to zero.
  always_comb begin
    rdVal = '0;
    for (int i = 0; i < NCH; i++) begin
      if (bus.addr == 5'(i * CH_STRIDE + OFF_CTRL))   rdVal = 32'(ctrlArr[i]);
      if (bus.addr == 5'(i * CH_STRIDE + OFF_PRESET)) rdVal = 32'(presetArr[i]);
      if (bus.addr == 5'(i * CH_STRIDE + OFF_COUNT))  rdVal = 32'(countArr[i]);
    end
  end

  assign bus.rd = rdVal;

endmodule

// File: tb/tb_timer_bank.sv
module tb_timer_bank;
  localparam int NCH = 6;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [NCH-1:0] irq;

  timer_bank_if bus();

  timer_bank #(.NCH(NCH), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: register contents per channel
  logic        mEn   [NCH];
  logic [1:0]  mMode [NCH];
  logic        mIm   [NCH];
  logic        mPend [NCH];
  logic [31:0] mPre  [NCH];
  logic [31:0] mCnt  [NCH];

  task automatic modelReset();
    for (int c = 0; c < NCH; c++) begin
      mEn[c] = 0; mMode[c] = 0; mIm[c] = 0; mPend[c] = 0; mPre[c] = 0; mCnt[c] = 0;
    end
  endtask

  function automatic logic [NCH-1:0] modelIrq();
    logic [NCH-1:0] v;
    for (int c = 0; c < NCH; c++) v[c] = mPend[c] & mIm[c];
    return v;
  endfunction

  function automatic logic [31:0] modelRead(input logic [4:0] a);
    int ch;
    int off;
    ch  = int'(a) / 4;
    off = int'(a) % 4;
    if (ch >= NCH) return 32'h0;
    case (off)
      0: return {27'h0, mPend[ch], mIm[ch], mMode[ch], mEn[ch]};
      1: return mPre[ch];
      2: return mCnt[ch];
      default: return 32'h0;
    endcase
  endfunction

  // One clock edge: natural timer behaviour first, then bus-write overrides.
  task automatic modelEdge(input logic wv, input logic [4:0] a, input logic [31:0] d);
    logic        fire;
    logic        hit;
    int          off;
    logic        nEn;
    logic [1:0]  nMode;
    logic        nIm;
    logic        nPend;
    logic [31:0] nPre;
    logic [31:0] nCnt;
    for (int c = 0; c < NCH; c++) begin
      hit   = wv && (int'(a) / 4 == c);
      off   = int'(a) % 4;
      fire  = mEn[c] && (mCnt[c] == 32'd1);
      nEn = mEn[c]; nMode = mMode[c]; nIm = mIm[c]; nPend = mPend[c];
      nPre = mPre[c]; nCnt = mCnt[c];
      if (fire) begin
        nPend = 1;
        if (mMode[c] == 2'b01) nCnt = mPre[c];
        else begin nCnt = 0; nEn = 0; end
      end else if (mEn[c] && mCnt[c] > 0) begin
        nCnt = mCnt[c] - 1;
      end
      if (hit && off == 1) begin nPre = d; nCnt = d; end
      if (hit && off == 0) begin
        nEn = d[0]; nMode = d[2:1]; nIm = d[3];
        if (d[4] && !fire) nPend = 0;
      end
      mEn[c] = nEn; mMode[c] = nMode; mIm[c] = nIm; mPend[c] = nPend;
      mPre[c] = nPre; mCnt[c] = nCnt;
    end
  endtask

  task automatic tick(input logic wv, input logic [4:0] a, input logic [3:0] b, input logic [31:0] d);
    bus.sel = wv; bus.we = wv; bus.addr = a; bus.be = b; bus.wd = d;
    @(posedge clk);
    modelEdge(wv && (b == 4'hF), a, d);
    #1;
    bus.sel = 0; bus.we = 0; bus.be = 0;
    checks++;
    if (irq !== modelIrq()) begin
      errors++;
      $display("FAIL irq_model t=%0t got %b want %b", $time, irq, modelIrq());
    end
  endtask

  task automatic idle();
    tick(1'b0, 5'd0, 4'h0, 32'h0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    tick(1'b1, a, 4'hF, d);
  endtask

  task automatic readChk(input logic [4:0] a);
    bus.addr = a;
    #1;
    checks++;
    if (bus.rd !== modelRead(a)) begin
      errors++;
      $display("FAIL rd_model addr=%0d got %h want %h", a, bus.rd, modelRead(a));
    end
  endtask

  task automatic expectRd(input logic [4:0] a, input logic [31:0] exp, input string name);
    bus.addr = a;
    #1;
    checks++;
    if (bus.rd !== exp) begin
      errors++;
      $display("FAIL %s addr=%0d got %h want %h", name, a, bus.rd, exp);
    end
  endtask

  task automatic expectIrq(input logic [NCH-1:0] exp, input string name);
    checks++;
    if (irq !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %b want %b", name, $time, irq, exp);
    end
  endtask

  task automatic test_reset();
    bus.sel = 0; bus.we = 0; bus.addr = 0; bus.be = 0; bus.wd = 0;
    reset = 0;
    modelReset();
    #2;
    expectIrq('0, "reset_irq");
    @(negedge clk) reset = 1;
    @(posedge clk);
    #1;
    for (int a = 0; a < 32; a++) begin
      expectRd(5'(a), 32'h0, "reset_rd");
      idle();
    end
    tick(1'b1, 5'd0, 4'b0011, 32'h9);
    expectRd(5'd0, 32'h0, "partial_be_ctrl");
    tick(1'b1, 5'd1, 4'b0011, 32'h7);
    expectRd(5'd1, 32'h0, "partial_be_preset");
    wr(5'd24, 32'h1F);
    expectRd(5'd24, 32'h0, "out_of_range");
    wr(5'd2, 32'h7);
    expectRd(5'd2, 32'h0, "count_ro");
  endtask

  task automatic test_oneshot();
    wr(5'd1, 32'd5);
    expectRd(5'd2, 32'd5, "os_preload");
    wr(5'd0, 32'h9);
    expectRd(5'd2, 32'd5, "os_count");
    for (int k = 1; k <= 5; k++) begin
      idle();
      expectRd(5'd2, 32'(5 - k), "os_count");
      expectIrq((k == 5) ? 6'b000001 : 6'b000000, "os_irq_latency");
    end
    expectRd(5'd0, 32'h18, "os_ctrl_after");
    idle();
    expectRd(5'd2, 32'd0, "os_count_hold");
    wr(5'd0, 32'h10);
    expectIrq('0, "os_w1c");
  endtask

  task automatic test_reload();
    wr(5'd9, 32'd3);
    wr(5'd8, 32'hB);
    idle(); expectIrq(6'b000000, "rl_e1");
    idle(); expectIrq(6'b000000, "rl_e2");
    idle(); expectIrq(6'b000100, "rl_e3");
    idle(); expectIrq(6'b000100, "rl_e4");
    wr(5'd8, 32'h1B); expectIrq(6'b000000, "rl_w1c_drop");
    idle(); expectIrq(6'b000100, "rl_reassert");
    expectRd(5'd10, 32'd3, "rl_count_reload");
    wr(5'd8, 32'h10);
    expectIrq(6'b000000, "rl_stop");
  endtask

  task automatic test_w1c_expiry();
    int  seen;
    bit  done;
    seen = 0;
    done = 0;
    wr(5'd5, 32'd4);
    wr(5'd4, 32'hB);
    for (int k = 0; k < 20 && !done; k++) begin
      if (mEn[1] && mCnt[1] == 32'd1) begin
        if (seen == 1) begin
          wr(5'd4, 32'h1B);
          expectIrq(6'b000010, "w1c_expiry_irq");
          expectRd(5'd4, 32'h1B, "w1c_expiry_ctrl");
          done = 1;
        end else begin
          seen++;
          idle();
        end
      end else begin
        idle();
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL w1c_expiry_timeout got no expiry want expiry");
    end
    wr(5'd4, 32'h10);
  endtask

  task automatic test_mask();
    wr(5'd13, 32'd2);
    wr(5'd12, 32'h1);
    idle(); idle(); idle();
    expectRd(5'd12, 32'h10, "mask_ctrl");
    expectIrq(6'b000000, "mask_irq_off");
    wr(5'd12, 32'h8);
    expectIrq(6'b001000, "mask_irq_on");
    wr(5'd12, 32'h10);
  endtask

  task automatic test_random();
    logic [4:0]  a;
    logic [3:0]  b;
    logic [31:0] d;
    for (int k = 0; k < 400; k++) begin
      a = 5'($urandom_range(0, 31));
      b = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      d = (a[1:0] == 2'd1) ? 32'($urandom_range(0, 6)) : $urandom;
      if ($urandom_range(0, 2) == 0) tick(1'b1, a, b, d);
      else idle();
      readChk(5'($urandom_range(0, 31)));
      readChk(5'($urandom_range(0, 23)));
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 0;
    modelReset();
    reset = 0;
    #1;
    @(negedge clk) reset = 1;
    @(posedge clk);
    #1;
    wr(5'd21, 32'd1);
    wr(5'd20, 32'h9);
    idle();
    wr(5'd1, 32'd10);
    wr(5'd0, 32'h1);
    for (int k = 0; k < 20 && !found; k++) begin
      if (mCnt[0] == 32'd3) found = 1;
      else idle();
    end
    if (!found) begin
      errors++;
      $display("FAIL midreset_setup_timeout got no count=3 want count=3");
    end
    expectIrq(6'b100000, "midreset_pre_irq");
    #1;
    reset = 0;
    #1;
    expectIrq('0, "midreset_irq");
    expectRd(5'd2, 32'h0, "midreset_count");
    expectRd(5'd20, 32'h0, "midreset_ctrl5");
    expectRd(5'd0, 32'h0, "midreset_ctrl0");
    modelReset();
    @(negedge clk) reset = 1;
    @(posedge clk);
    #1;
    wr(5'd17, 32'd0);
    wr(5'd16, 32'h9);
    for (int k = 0; k < 20; k++) begin
      idle();
      expectIrq('0, "preset0_no_irq");
    end
    expectRd(5'd18, 32'h0, "preset0_count");
    expectRd(5'd16, 32'h9, "preset0_ctrl");
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_reload();
    test_w1c_expiry();
    test_mask();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/timer_bank.md
Name: timer_bank

Overview:
- Parametrised bank of NCH down-counting timers on the processor's peripheral (Pr) bus.
- Next generation of the single-timer device: per-channel one-shot or auto-reload mode, per-channel interrupt mask, and a write-1-to-clear pending bit.
- Drives the CPU's HWInt lines directly, replacing the tied-off HWInt inputs used in CPU-level simulation until now.

Parameters:
- NCH, 6, number of timer channels (6 matches HWInt[7:2]); legal range 1..8.
- CNT_W, 32, counter/preset width in bits; legal range 1..32; register reads zero-extend to 32 bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserts when 0, releases synchronously to clk).
- sel  input  1  bridge select for this device.
- addr  input  5  word offset within the device (byte address bits [6:2]).
- we  input  1  write strobe, valid only with sel.
- be  input  4  byte enables; a write takes effect only when be == 4'b1111.
- wd  input  32  write data.
- rd  output  32  read data, combinational from addr.
- irq  output  NCH  per-channel interrupt request to HWInt.

Behaviour:
- Register map: channel i occupies word offsets 4i..4i+3.
  - +0 CTRL: bit0 EN; bits2:1 MODE (00 one-shot, 01 auto-reload, 1x reserved and treated as one-shot); bit3 IM (irq mask, 1 = enabled); bit4 PEND. Other bits read 0.
  - +1 PRESET (R/W).
  - +2 COUNT (read-only).
  - +3 reserved, reads 0.
- Offsets at or above 4*NCH read 0; writes to them are ignored.
- Reset values: every CTRL, PRESET and COUNT is 0, so irq = 0. rd reflects the zeroed registers.
- Writes commit on the clk edge when sel & we & (be == 4'b1111).
  - PRESET write: loads PRESET and COUNT with wd[CNT_W-1:0] on the same edge.
  - CTRL write: updates EN, MODE and IM. A 1 in bit4 clears PEND (W1C); a 0 in bit4 leaves PEND unchanged.
  - COUNT writes are ignored.
- Counting: when EN = 1 and COUNT > 0, COUNT decrements by 1 each cycle.
- Expiry is the cycle in which EN = 1 and COUNT == 1. On the following edge:
  - PEND is set to 1.
  - One-shot: COUNT becomes 0 and EN is cleared.
  - Auto-reload: COUNT becomes PRESET and EN stays 1, so the period is PRESET cycles.
- EN = 1 with COUNT == 0 (e.g. PRESET = 0): no counting, no expiry, PEND is not set.
- irq[i] = PEND_i & IM_i, combinational from registers, no extra latency. PEND stays set until cleared by W1C or reset.
- Latency: first expiry occurs PRESET cycles after the edge that sets EN (COUNT = PRESET already loaded). irq rises on that same edge.
- Simultaneous events in one cycle:
  - W1C of PEND and expiry together: PEND is set (expiry wins).
  - CTRL write and expiry together: the written EN/MODE/IM take effect. In auto-reload the reload still occurs; in one-shot the written EN value wins over the auto-clear.
  - PRESET write and expiry together: COUNT takes the written value, and PEND is still set.
- Reset mid-count: all state clears immediately and asynchronously; irq drops without waiting for a clock edge.
- Arithmetic: COUNT is unsigned CNT_W bits and never wraps below 0. Writes take only wd[CNT_W-1:0].

Decomposition:
- Package timer_bank_pkg holds:
  - register offsets (CTRL = 0, PRESET = 1, COUNT = 2);
  - CTRL bit positions (EN, MODE_LSB, MODE_MSB, IM, PEND);
  - MODE encodings (ONESHOT = 2'b00, RELOAD = 2'b01);
  - the channel stride (4).
- Sub-module timer_channel, one instance per channel via generate:
  - contains the CTRL/PRESET/COUNT registers, expiry logic and irq;
  - takes decoded per-channel write strobes (ctrl_we, preset_we) and wd;
  - exposes ctrl, preset and count for the top-level read mux.
- The top level (timer_bank) holds only address decode, the read mux and the irq concatenation.

Test Plan:
- Reset, then read every register at offsets 0..23 -> all read 0x0, irq = 0. Write with be = 4'b0011 -> register unchanged.
- Ch0 one-shot: PRESET = 5; CTRL = 0x9 (EN, IM) -> COUNT reads 5,4,3,2,1,0; irq[0] rises exactly 5 cycles after the CTRL write edge; CTRL then reads 0x18 (EN cleared, PEND set).
- Ch2 auto-reload: PRESET = 3; CTRL = 0xB -> PEND set every 3 cycles. W1C (write 0x1B) -> irq[2] drops for 1..2 cycles, then re-asserts at the next expiry. Other channels' irq stay 0.
- W1C issued on the expiry cycle of ch1 (PRESET = 4, reload) -> PEND remains 1 and irq[1] stays high.
- Mask: ch3 with IM = 0 expires -> PEND = 1, irq[3] = 0. Then CTRL IM = 1 -> irq[3] = 1 the next cycle.
- Drop reset to 0 mid-count (ch0 COUNT = 3, PEND = 1 on ch5) -> irq = 0 and all registers read 0 before the next clk edge. After release, a PRESET = 0 with EN = 1 -> no irq for 20 cycles.
